agc_memory_cycle_controller: RTL and testbench

- Sits directly downstream of the sequence generator and consumes its 11 timing pulses, TP1..TP11.
- Each pulse is high for 2 clk periods, and a full memory cycle is 22 clk periods.
- Runs one erasable-memory cycle per request: address, destructive read, latch into G, then restore or overwrite.
- Provides a req/busy/done handshake to the control unit and a checker that flags out-of-order timing pulses.

---
 rtl/agc_memory_cycle_controller.sv | 199 +++++++++++++++++++
 tb/tb_agc_memory_cycle_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_memory_cycle_controller.sv
// agc_memory_cycle_controller
// Runs one erasable-memory cycle per request, paced by timing pulses TP1..TP11.
// The cycle is address, destructive read, latch into G (rdata), then restore or overwrite.
// Ports:
//   clk, reset        : system clock and synchronous active-high reset
//   tp[NTP-1:0]       : timing pulses from the sequence generator (tp[0] = TP1)
//   req, we, addr,
//   wdata             : access request and its payload; req is sampled only while idle
//   busy, done        : handshake outputs; done is a one-clk completion pulse
//   rdata             : G register holding the word from the last cycle
//   mem_addr, mem_rd,
//   mem_wr, mem_wdata,
//   mem_rdata         : memory array interface
//   seq_err           : sticky flag for an out-of-order timing pulse
module agc_memory_cycle_controller #(
  parameter int unsigned AW  = 11,
  parameter int unsigned DW  = 16,
  parameter int unsigned NTP = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NTP-1:0] tp,
  input  logic           req,
  input  logic           we,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  wdata,
  output logic           busy,
  output logic           done,
  output logic [DW-1:0]  rdata,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic           seq_err
);

  localparam int unsigned PW = $clog2(NTP + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT_T1 = 3'd1;
  localparam logic [2:0] ADDR    = 3'd2;
  localparam logic [2:0] READ    = 3'd3;
  localparam logic [2:0] LATCH   = 3'd4;
  localparam logic [2:0] MODIFY  = 3'd5;
  localparam logic [2:0] WRITE   = 3'd6;
  localparam logic [2:0] FINISH  = 3'd7;

  logic [2:0]     state, state_d;
  logic [NTP-1:0] tp_q, rise;
  logic           sync, sync_d;
  logic [PW-1:0]  phase, phase_d;
  logic           rise_any, rise_multi, legal, seq_fault;
  logic [PW-1:0]  rise_k;

  logic           busy_d, done_d, mem_rd_d, mem_wr_d, seq_err_d;
  logic [DW-1:0]  rdata_d, mem_wdata_d;
  logic [AW-1:0]  mem_addr_d;
  logic [AW-1:0]  lat_addr, lat_addr_d;
  logic           lat_we, lat_we_d;
  logic [DW-1:0]  lat_wdata, lat_wdata_d;

  // Pulse history is left unreset so a pulse already high across reset is not seen as a rise.
  always_ff @(posedge clk) begin
    tp_q <= tp;
  end

  assign rise = tp & ~tp_q;

  // Decode which pulse rose and whether it follows the previous one.
  always_comb begin
    rise_any   = |rise;
    rise_multi = |(rise & (rise - NTP'(1)));
    rise_k     = '0;
    for (int i = 0; i < int'(NTP); i++) begin
      if (rise[i]) rise_k = PW'(i + 1);
    end
    if (rise_k == PW'(1)) legal = (phase == PW'(NTP));
    else                  legal = (rise_k == phase + PW'(1));
    seq_fault = sync & rise_any & (rise_multi | ~legal);
  end

  // Sync/phase tracking, independent of the access FSM.
  always_comb begin
    sync_d  = sync;
    phase_d = phase;
    if (!sync) begin
      if (rise[0]) begin
        sync_d  = 1'b1;
        phase_d = PW'(1);
      end
    end else if (rise_any && !seq_fault) begin
      phase_d = rise_k;
    end
  end

  // Access FSM next-state and registered-output next values.
  always_comb begin
    state_d     = state;
    busy_d      = busy;
    done_d      = 1'b0;
    rdata_d     = rdata;
    mem_addr_d  = mem_addr;
    mem_rd_d    = mem_rd;
    mem_wr_d    = mem_wr;
    mem_wdata_d = mem_wdata;
    seq_err_d   = seq_err;
    lat_addr_d  = lat_addr;
    lat_we_d    = lat_we;
    lat_wdata_d = lat_wdata;
    if (seq_fault) begin
      seq_err_d = 1'b1;
      mem_rd_d  = 1'b0;
      mem_wr_d  = 1'b0;
      busy_d    = 1'b0;
      state_d   = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req && !busy && !seq_err) begin
            lat_addr_d  = addr;
            lat_we_d    = we;
            lat_wdata_d = wdata;
            busy_d      = 1'b1;
            state_d     = WAIT_T1;
          end
        end
        WAIT_T1: if (rise[0]) begin
          mem_addr_d = lat_addr;
          state_d    = ADDR;
        end
        ADDR: if (rise[1]) begin
          mem_rd_d = 1'b1;
          state_d  = READ;
        end
        READ: if (rise[3]) begin
          rdata_d  = mem_rdata;
          mem_rd_d = 1'b0;
          state_d  = LATCH;
        end
        LATCH: if (rise[5]) begin
          if (lat_we) rdata_d = lat_wdata;
          state_d = MODIFY;
        end
        MODIFY: if (rise[6]) begin
          mem_wdata_d = rdata;
          mem_wr_d    = 1'b1;
          state_d     = WRITE;
        end
        WRITE: if (rise[8]) begin
          mem_wr_d = 1'b0;
          state_d  = FINISH;
        end
        FINISH: if (rise[9]) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sync      <= 1'b0;
      phase     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      seq_err   <= 1'b0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else begin
      state     <= state_d;
      sync      <= sync_d;
      phase     <= phase_d;
      busy      <= busy_d;
      done      <= done_d;
      rdata     <= rdata_d;
      mem_addr  <= mem_addr_d;
      mem_rd    <= mem_rd_d;
      mem_wr    <= mem_wr_d;
      mem_wdata <= mem_wdata_d;
      seq_err   <= seq_err_d;
      lat_addr  <= lat_addr_d;
      lat_we    <= lat_we_d;
      lat_wdata <= lat_wdata_d;
    end
  end

endmodule

// File: tb/tb_agc_memory_cycle_controller.sv
// Directed bench for agc_memory_cycle_controller with a free-running pulse generator,
// a behavioural memory array and hand-computed expectations.
module tb_agc_memory_cycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] tp = '0;
  logic        req, we;
  logic [10:0] addr;
  logic [15:0] wdata;
  logic        busy, done, mem_rd, mem_wr, seq_err;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [10:0] mem_addr;

  int checks = 0;
  int errors = 0;

  agc_memory_cycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .tp        (tp),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  // Pulse generator: each pulse high 2 clks, updated on negedge; manual override when gen_en=0.
  int          cnt = 0;
  logic        gen_en = 1'b1;
  logic [10:0] tp_man = '0;
  always @(negedge clk) begin
    if (gen_en) begin
      tp  = 11'(1) << (cnt / 2);
      cnt = (cnt == 21) ? 0 : cnt + 1;
    end else begin
      tp = tp_man;
    end
  end

  // Edge counter and most recent TP1 rise edge.
  int   cyc = 0;
  int   tp1_edge = 0;
  logic tp0_prev = 1'b0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (tp[0] && !tp0_prev) tp1_edge = cyc;
    tp0_prev = tp[0];
  end

  // Memory array with a preload port.
  logic [15:0] mem [0:2047];
  logic        pre_en = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [15:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en)      mem[pre_addr] <= pre_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem_rd ? mem[mem_addr] : 16'h0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return mem_rd;
      1:       return mem_wr;
      default: return done;
    endcase
  endfunction

  task automatic wait_high(input int sel, input string tag);
    int n = 0;
    while (sig(sel) !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < 64), 64'd1);
  endtask

  task automatic preload(input logic [10:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  // Full access with timing checks relative to the TP1 rise that starts it.
  task automatic run_access(input logic w, input logic [10:0] a, input logic [15:0] d,
                            input logic [15:0] exp_rd, input logic [15:0] exp_fin,
                            input string tag);
    int n;
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    chk({tag, "_busy_on"}, 64'(busy), 64'd1);
    req = 1'b0;
    wait_high(0, {tag, "_rd_wait"});
    chk({tag, "_rd_start"}, 64'(cyc - tp1_edge), 64'd2);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(a));
    n = 0;
    while (mem_rd === 1'b1 && n < 16) begin n++; tick(); end
    chk({tag, "_rd_len"}, 64'(n), 64'd4);
    chk({tag, "_rdata_read"}, 64'(rdata), 64'(exp_rd));
    wait_high(1, {tag, "_wr_wait"});
    chk({tag, "_wr_start"}, 64'(cyc - tp1_edge), 64'd12);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(exp_fin));
    n = 0;
    while (mem_wr === 1'b1 && n < 16) begin n++; tick(); end
    chk({tag, "_wr_len"}, 64'(n), 64'd4);
    wait_high(2, {tag, "_done_wait"});
    chk({tag, "_done_lat"}, 64'(cyc - tp1_edge), 64'd18);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_rdata_final"}, 64'(rdata), 64'(exp_fin));
    chk({tag, "_mem_final"}, 64'(mem[a]), 64'(exp_fin));
  endtask

  initial begin
    int   acc;
    int   n;
    logic quiet;

    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tick(); tick(); tick();
    chk("reset_outputs", {busy, done, mem_rd, mem_wr, seq_err, rdata, mem_addr, mem_wdata}, 64'd0);
    reset = 1'b0;

    // Idle generator cycles.
    quiet = 1'b0;
    for (int i = 0; i < 66; i++) begin
      tick();
      quiet = quiet | busy | done | mem_rd | mem_wr | seq_err;
    end
    chk("t1_quiet", 64'(quiet), 64'd0);
    chk("t1_sync", 64'(dut.sync), 64'd1);

    // Read with restore.
    preload(11'h0A5, 16'h1234);
    run_access(1'b0, 11'h0A5, 16'h0000, 16'h1234, 16'h1234, "t2");

    // Write.
    preload(11'h7FF, 16'h0F0F);
    run_access(1'b1, 11'h7FF, 16'hBEEF, 16'h0F0F, 16'hBEEF, "t3");

    // req held high; payload changed while busy; re-accepted the clk after done.
    preload(11'h010, 16'h0000);
    preload(11'h020, 16'h1111);
    req = 1'b1; we = 1'b1; addr = 11'h010; wdata = 16'hAAAA;
    tick();
    chk("t4a_busy", 64'(busy), 64'd1);
    addr = 11'h020; wdata = 16'h5555;
    wait_high(2, "t4a_done_wait");
    chk("t4a_mem_first", 64'(mem[11'h010]), 64'hAAAA);
    chk("t4a_mem_untouched", 64'(mem[11'h020]), 64'h1111);
    chk("t4a_rdata", 64'(rdata), 64'hAAAA);
    tick();
    chk("t4b_done_once", 64'(done), 64'd0);
    chk("t4b_busy_reaccept", 64'(busy), 64'd1);
    req = 1'b0;
    wait_high(2, "t4b_done_wait");
    chk("t4b_done_lat", 64'(cyc - tp1_edge), 64'd18);
    chk("t4b_mem", 64'(mem[11'h020]), 64'h5555);
    tick();

    // Acceptance on the same edge as a TP1 rise waits for the following TP1.
    n = 0;
    while (cnt != 0 && n < 30) begin tick(); n++; end
    req = 1'b1; we = 1'b0; addr = 11'h0A5; wdata = 16'h0000;
    tick();
    acc = cyc;
    chk("t4c_tp1_on_accept", 64'(tp1_edge), 64'(acc));
    chk("t4c_busy", 64'(busy), 64'd1);
    req = 1'b0;
    wait_high(0, "t4c_rd_wait");
    chk("t4c_rd_start", 64'(cyc - acc), 64'd24);
    wait_high(2, "t4c_done_wait");
    chk("t4c_done_lat", 64'(cyc - acc), 64'd40);
    chk("t4c_rdata", 64'(rdata), 64'h1234);
    tick();

    // Skipped pulse mid-access.
    req = 1'b1; we = 1'b0; addr = 11'h0A5;
    tick();
    req = 1'b0;
    n = 0;
    while (cnt != 0 && n < 30) begin tick(); n++; end
    gen_en = 1'b0;
    tp_man = 11'h001;
    tick();
    chk("t5_addr_phase", 64'(mem_addr), 64'h0A5);
    tick();
    tp_man = 11'h004;
    tick();
    chk("t5_seq_err", 64'(seq_err), 64'd1);
    chk("t5_outputs", {busy, done, mem_rd, mem_wr}, 64'd0);
    tp_man = 11'h000;
    req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_req_ignored", 64'(busy), 64'd0);
    gen_en = 1'b1;
    quiet = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      quiet = quiet | busy | done;
    end
    chk("t5_still_ignored", 64'(quiet), 64'd0);
    chk("t5_sticky", 64'(seq_err), 64'd1);
    req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_cleared", 64'(seq_err), 64'd0);

    // Reset while writing.
    req = 1'b1; we = 1'b0; addr = 11'h0A5;
    tick();
    req = 1'b0;
    wait_high(1, "t6_wr_wait");
    reset = 1'b1;
    tick();
    chk("t6_reset_outputs", {busy, done, mem_rd, mem_wr, seq_err, rdata, mem_addr, mem_wdata}, 64'd0);
    reset = 1'b0;
    quiet = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      quiet = quiet | busy | done;
    end
    chk("t6_no_done", 64'(quiet), 64'd0);
    preload(11'h001, 16'h4321);
    run_access(1'b0, 11'h001, 16'h0000, 16'h4321, 16'h4321, "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
